// File: rtl/geogenius_pkg.sv
// geogenius_pkg: state codes and default sequence ROM contents for the geogenius game core.
package geogenius_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      MOSTRA      = 4'h2,
      GAP         = 4'h3,
      ESPERA      = 4'h4,
      COMPARA     = 4'h5,
      FIM_GANHOU  = 4'hA,
      FIM_PERDEU  = 4'hB,
      FIM_TIMEOUT = 4'hC
   } estado_t;

   localparam int MAX_BOTOES = 16;

   function automatic logic [MAX_BOTOES-1:0] rom_entry(input int unsigned i, input int unsigned n);
      return MAX_BOTOES'(1) << (i % n);
   endfunction

endpackage

// File: rtl/geogenius_rom.sv
// geogenius_rom: combinational sequence ROM, address to one-hot button entry.
module geogenius_rom
   import geogenius_pkg::*;
#(
   parameter int N_BOTOES = 8,
   parameter int N_NIVEIS = 16,
   localparam int AW = $clog2(N_NIVEIS)
) (
   input  logic [AW-1:0]       addr,
   output logic [N_BOTOES-1:0] entry
);

   assign entry = N_BOTOES'(rom_entry(32'(addr), N_BOTOES));

endmodule

// File: rtl/geogenius_nucleo.sv
// geogenius_nucleo: parametrised Simon-style sequence game core for N buttons.
// Optional macro GEOGENIUS_TIMEOUT_EN builds the per-play timeout; otherwise ESPERA waits forever.
module geogenius_nucleo
   import geogenius_pkg::*;
#(
   parameter int N_BOTOES       = 8,
   parameter int N_NIVEIS       = 16,
   parameter int LED_CICLOS     = 1000,
   parameter int GAP_CICLOS     = 250,
   parameter int TIMEOUT_CICLOS = 5000
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            jogar,
   input  logic [N_BOTOES-1:0]             botoes,
   input  logic                            dificuldade,
   output logic                            ganhou,
   output logic                            perdeu,
   output logic                            timeout,
   output logic                            pronto,
   output logic [N_BOTOES-1:0]             leds,
   output logic [$clog2(N_NIVEIS+1)-1:0]   score,
   output logic [3:0]                      db_estado
);

   localparam int NW   = $clog2(N_NIVEIS);
   localparam int SW   = $clog2(N_NIVEIS+1);
   localparam int TMAX = LED_CICLOS > GAP_CICLOS ? LED_CICLOS : GAP_CICLOS;
   localparam int TW   = $clog2(TMAX+1);

   estado_t             st;
   logic [NW-1:0]       nivel, idx, jogada;
   logic [SW-1:0]       limite;
   logic [TW-1:0]       tmr;
   logic [N_BOTOES-1:0] botoes_q, jogada_reg, rom_show, rom_cmp;
   logic                press, led_fim, gap_fim, ultimo, tmo_fim;

   assign press   = |botoes && !(|botoes_q);
   assign led_fim = tmr == TW'(LED_CICLOS-1);
   assign gap_fim = tmr == TW'(GAP_CICLOS-1);
   assign ultimo  = SW'(nivel) + SW'(1) == limite;

   assign ganhou    = st == FIM_GANHOU;
   assign perdeu    = st == FIM_PERDEU;
   assign pronto    = st == FIM_GANHOU || st == FIM_PERDEU || st == FIM_TIMEOUT;
   assign db_estado = st;

   // One port looks ahead to the entry about to be displayed, the other checks the play.
   geogenius_rom #(.N_BOTOES(N_BOTOES), .N_NIVEIS(N_NIVEIS)) u_rom_show (
      .addr  (st == GAP ? idx + NW'(1) : NW'(0)),
      .entry (rom_show)
   );

   geogenius_rom #(.N_BOTOES(N_BOTOES), .N_NIVEIS(N_NIVEIS)) u_rom_cmp (
      .addr  (jogada),
      .entry (rom_cmp)
   );

`ifdef GEOGENIUS_TIMEOUT_EN
   localparam int OW = $clog2(TIMEOUT_CICLOS+1);
   logic [OW-1:0] tmo;
   assign tmo_fim = tmo == OW'(TIMEOUT_CICLOS-1);
   assign timeout = st == FIM_TIMEOUT;
   // Restarts on every entry into ESPERA, including the return from COMPARA.
   always_ff @(posedge clock or posedge reset)
      if (reset)
         tmo <= '0;
      else
         tmo <= st == ESPERA ? tmo + OW'(1) : '0;
`else
   assign tmo_fim = TIMEOUT_CICLOS < 0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         st         <= INICIAL;
         nivel      <= '0;
         idx        <= '0;
         jogada     <= '0;
         limite     <= '0;
         tmr        <= '0;
         score      <= '0;
         leds       <= '0;
         botoes_q   <= '0;
         jogada_reg <= '0;
      end else begin
         botoes_q <= botoes;
         case (st)
            PREPARA: begin
               nivel  <= '0;
               idx    <= '0;
               score  <= '0;
               limite <= dificuldade ? SW'(N_NIVEIS) : SW'(N_NIVEIS/2);
               tmr    <= '0;
               leds   <= rom_show;
               st     <= MOSTRA;
            end
            MOSTRA:
               if (led_fim) begin
                  tmr  <= '0;
                  leds <= '0;
                  st   <= GAP;
               end else
                  tmr <= tmr + TW'(1);
            GAP:
               if (!gap_fim)
                  tmr <= tmr + TW'(1);
               else if (idx == nivel) begin
                  tmr    <= '0;
                  jogada <= '0;
                  leds   <= botoes;
                  st     <= ESPERA;
               end else begin
                  tmr  <= '0;
                  idx  <= idx + NW'(1);
                  leds <= rom_show;
                  st   <= MOSTRA;
               end
            ESPERA:
               if (press) begin
                  jogada_reg <= botoes;
                  leds       <= botoes;
                  st         <= COMPARA;
               end else if (tmo_fim) begin
                  leds <= '0;
                  st   <= FIM_TIMEOUT;
               end else
                  leds <= botoes;
            COMPARA:
               if (jogada_reg != rom_cmp) begin
                  leds <= '0;
                  st   <= FIM_PERDEU;
               end else if (jogada != nivel) begin
                  jogada <= jogada + NW'(1);
                  leds   <= botoes;
                  st     <= ESPERA;
               end else if (ultimo) begin
                  score <= limite;
                  leds  <= '0;
                  st    <= FIM_GANHOU;
               end else begin
                  score <= score + SW'(1);
                  nivel <= nivel + NW'(1);
                  idx   <= '0;
                  tmr   <= '0;
                  leds  <= rom_show;
                  st    <= MOSTRA;
               end
            default:
               if (jogar) st <= PREPARA;
         endcase
      end

endmodule

// File: tb/tb_geogenius_nucleo.sv
// tb_geogenius_nucleo: directed and randomized games checked every cycle against a game-level model.
module tb_geogenius_nucleo;

   localparam int NB   = 8;
   localparam int NN   = 4;
   localparam int LED  = 4;
   localparam int GAPC = 2;
   localparam int TO   = 20;
`ifdef GEOGENIUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clock, reset, jogar, dificuldade;
   logic [NB-1:0] botoes, leds;
   logic          ganhou, perdeu, timeout, pronto;
   logic [2:0]    score;
   logic [3:0]    db_estado;

   int vectors, miscompares;

   geogenius_nucleo #(
      .N_BOTOES(NB), .N_NIVEIS(NN), .LED_CICLOS(LED), .GAP_CICLOS(GAPC), .TIMEOUT_CICLOS(TO)
   ) dut (
      .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .dificuldade(dificuldade),
      .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
      .leds(leds), .score(score), .db_estado(db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] rom(input int i);
      logic [7:0] one;
      one = 8'd1;
      return one << (i % NB);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- game-level reference model ----------------
   logic [3:0] e_st;
   logic [7:0] e_leds, bcur, bq;
   logic [2:0] e_score;
   bit         j, dsm, abort;

   task automatic nxt();
      @(posedge clock);
      bq   = bcur;
      bcur = reset ? 8'h00 : botoes;
      j    = jogar;
      dsm  = dificuldade;
      if (reset) abort = 1;
   endtask

   task automatic hold(input int n);
      for (int c = 0; c < n && !abort; c++) nxt();
   endtask

   task automatic partida();
      int lim, t;
      logic [7:0] cap;
      do nxt(); while (!abort && !j);
      if (abort) return;
      e_st = 4'h1; e_leds = 8'h00;
      nxt(); if (abort) return;
      lim = dsm ? NN : NN/2;
      e_score = 3'd0;
      for (int k = 0; k < lim; k++) begin
         for (int i = 0; i <= k; i++) begin
            e_st = 4'h2; e_leds = rom(i);
            hold(LED); if (abort) return;
            e_st = 4'h3; e_leds = 8'h00;
            hold(GAPC); if (abort) return;
         end
         for (int p = 0; p <= k; p++) begin
            e_st = 4'h4; e_leds = bcur; t = 0;
            forever begin
               nxt(); if (abort) return;
               if (bcur != 0 && bq == 0) break;
               if (TO_EN && t == TO-1) begin e_st = 4'hC; e_leds = 8'h00; return; end
               e_leds = bcur; t++;
            end
            cap = bcur; e_st = 4'h5; e_leds = bcur;
            nxt(); if (abort) return;
            if (cap != rom(p)) begin e_st = 4'hB; e_leds = 8'h00; return; end
         end
         if (k == lim-1) begin e_st = 4'hA; e_leds = 8'h00; e_score = 3'(lim); return; end
         e_score = 3'(k+1);
      end
   endtask

   initial begin
      e_st = 0; e_leds = 0; e_score = 0; bcur = 0; bq = 0; abort = 0;
      forever begin
         partida();
         if (abort) begin abort = 0; e_st = 0; e_leds = 0; e_score = 0; end
      end
   end

   always @(negedge clock) begin
      logic [3:0] xs;
      xs = reset ? 4'h0 : e_st;
      chk("db_estado", db_estado, xs);
      chk("leds", leds, reset ? 8'h00 : e_leds);
      chk("score", score, reset ? 3'd0 : e_score);
      chk("ganhou", ganhou, xs == 4'hA);
      chk("perdeu", perdeu, xs == 4'hB);
      chk("timeout", timeout, xs == 4'hC);
      chk("pronto", pronto, xs >= 4'hA);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic wait_st(input logic [3:0] s, input string nm);
      int c = 0;
      while (db_estado != s && c < 400) begin tick(1); c++; end
      chk(nm, db_estado, s);
   endtask

   task automatic wait_fim(input string nm);
      int c = 0;
      while (!pronto && c < 2000) begin tick(1); c++; end
      chk(nm, pronto, 1);
   endtask

   task automatic start(input bit dif, input int n);
      dificuldade = dif; jogar = 1'b1; tick(n); jogar = 1'b0;
   endtask

   task automatic press(input logic [7:0] b, input int h, input int r);
      botoes = b; tick(h); botoes = 8'h00; tick(r);
   endtask

   logic [7:0] q[$];
   int n, p, c;

   initial begin
      vectors = 0; miscompares = 0;
      reset = 1'b1; jogar = 1'b0; dificuldade = 1'b0; botoes = 8'h00;
      tick(3);
      reset = 1'b0;
      tick(2);

      // reset in the middle of a display
      start(0, 2);
      wait_st(4'h2, "reach_mostra");
      tick(1);
      reset = 1'b1; tick(1);
      chk("rst_estado", db_estado, 0);
      chk("rst_leds", leds, 0);
      chk("rst_score", score, 0);
      chk("rst_pronto", pronto, 0);
      reset = 1'b0; tick(2);

      // easy game, correct play
      dificuldade = 1'b0; jogar = 1'b1; n = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (i == 4) jogar = 1'b0;
         if (db_estado == 4'h2 && leds == 8'h01) n++;
      end
      chk("led0_len", n, 4);
      press(8'h01, 3, 3);
      wait_st(4'h4, "esp_e1"); press(8'h01, 3, 3);
      wait_st(4'h4, "esp_e2"); press(8'h02, 3, 3);
      wait_fim("fim_easy");
      chk("easy_ganhou", ganhou, 1);
      chk("easy_score", score, 2);

      // hard game, full play, capture round-3 display
      start(1, 2);
      for (int k = 0; k < 3; k++)
         for (int pp = 0; pp <= k; pp++) begin
            wait_st(4'h4, "esp_h");
            press(rom(pp), 1, (k == 2 && pp == 2) ? 0 : 2);
         end
      tick(1);
      q.delete(); c = 0;
      while (db_estado != 4'h4 && c < 60) begin q.push_back(leds); tick(1); c++; end
      chk("r3_len", q.size(), 24);
      if (q.size() == 24)
         for (int i = 0; i < 4; i++)
            for (int s = 0; s < 6; s++)
               chk("r3_leds", q[i*6+s], s < 4 ? (1 << i) : 0);
      for (int pp = 0; pp < 4; pp++) begin
         wait_st(4'h4, "esp_h3"); press(rom(pp), 2, 2);
      end
      wait_fim("fim_hard");
      chk("hard_ganhou", ganhou, 1);
      chk("hard_score", score, 4);

      // losses: wrong entry in round 1, two-bit press in round 0
      start(0, 2);
      wait_st(4'h4, "esp_l0"); press(8'h01, 2, 2);
      wait_st(4'h4, "esp_l1"); press(8'h01, 2, 2);
      wait_st(4'h4, "esp_l2"); press(8'h04, 2, 2);
      wait_fim("fim_lose1");
      chk("lose1_perdeu", perdeu, 1);
      chk("lose1_score", score, 1);
      start(0, 2);
      wait_st(4'h4, "esp_l3"); press(8'h03, 2, 2);
      wait_fim("fim_lose0");
      chk("lose0_perdeu", perdeu, 1);
      chk("lose0_score", score, 0);

      // idle timeout, then a press in the last allowed cycle
      start(0, 2);
      wait_st(4'h4, "esp_t0");
      tick(19);
      chk("to_still_esp", db_estado, 4);
      tick(1);
      chk("to_flag", timeout, TO_EN);
      if (!pronto) press(8'h02, 2, 2);
      wait_fim("fim_to");
      start(0, 2);
      wait_st(4'h4, "esp_t1");
      tick(19);
      botoes = 8'h01; tick(1);
      chk("press_wins", db_estado, 5);
      botoes = 8'h00; tick(1);
      wait_st(4'h4, "esp_t2"); press(8'h02, 2, 2);
      wait_fim("fim_t2");

      // button held across the round boundary counts once
      start(0, 2);
      wait_st(4'h4, "esp_k0");
      botoes = 8'h01; tick(2);
      wait_st(4'h4, "esp_k1");
      tick(10);
      chk("held_esp", db_estado, 4);
      botoes = 8'h00; tick(2);
      press(8'h01, 2, 2);
      wait_st(4'h4, "esp_k2"); press(8'h02, 2, 2);
      wait_fim("fim_hold");
      chk("hold_ganhou", ganhou, 1);
      jogar = 1'b1; tick(1);
      chk("restart_prepara", db_estado, 1);
      jogar = 1'b0; tick(1);
      chk("restart_score", score, 0);

      // randomized games
      for (int g = 0; g < 25; g++) begin
         start(1'($urandom_range(0, 1)), $urandom_range(1, 3));
         c = 0; p = 0;
         while (!pronto && c < 200) begin
            n = 0;
            while (db_estado != 4'h4 && !pronto && n < 400) begin tick(1); n++; end
            if (pronto) break;
            tick(($urandom_range(0, 7) == 0) ? $urandom_range(15, 24) : $urandom_range(0, 3));
            press(($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : rom(p),
                  $urandom_range(1, 4), $urandom_range(1, 3));
            p = (db_estado == 4'h4) ? p + 1 : 0;
            c++;
         end
         chk("rand_fim", pronto, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
